decoder_scan_ctrl: RTL

- Upstream sequencer for the 2-to-4 decoder. Drives its select (Din) and enable (En) inputs.
- Walks a programmable subset of the four decoder outputs, one at a time. Each selected channel is held for a programmable dwell time, with a one-cycle blanking gap between channels.
- Runs a programmed number of full sweeps, or runs continuously. Used for display digit multiplexing and for scanning one-hot strobes.

---
 rtl/decoder_scan_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 2-to-4 decoder: visits the masked channels in ascending order,
// holding each for div+1 cycles with a one-cycle blank between channels.
module decoder_scan_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       mask,
    input  logic [3:0]       sweeps,
    output logic [1:0]       Din,
    output logic             En,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       mask_q;
    logic [3:0]       sweeps_q;
    logic [3:0]       sweep_q;
    logic [1:0]       din_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]       first_d;
    logic [1:0]       next_d;
    logic [3:0]       sweep_d;
    logic             wrap_d;
    logic             last_d;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur; falls back to the lowest set bit (wrap).
    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        r = lowest_set(m);
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = 2'(i);
        end
        return r;
    endfunction

    always_comb begin
        first_d = lowest_set(mask);
        next_d  = next_set(mask_q, din_q);
        wrap_d  = (next_d <= din_q);
        sweep_d = sweep_q + 4'd1;
        last_d  = wrap_d && (sweeps_q != 4'd0) && (sweep_d == sweeps_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            din_q   <= 2'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sweep_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop && (mask != 4'd0)) begin
                        div_q    <= div;
                        mask_q   <= mask;
                        sweeps_q <= sweeps;
                        din_q    <= first_d;
                        en_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        sweep_q  <= 4'd0;
                        state_q  <= DWELL;
                    end
                end
                DWELL: begin
                    if (stop) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == div_q) begin
                        if (wrap_d) sweep_q <= sweep_d;
                        en_q <= 1'b0;
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            din_q   <= next_d;
                            cnt_q   <= '0;
                            state_q <= BLANK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        en_q    <= 1'b1;
                        state_q <= DWELL;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Din  = din_q;
    assign En   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
